// File: rtl/mem_rd_pkg.sv
// Shared types and constants for the memory read streamer.
package mem_rd_pkg;

   localparam int unsigned DATA_WIDTH_DEF = 32;
   localparam int unsigned ADDR_WIDTH_DEF = 5;
   localparam int unsigned LEN_WIDTH_DEF  = 6;

   // Output buffer geometry: reads are throttled so buffer + in-flight never exceeds this.
   localparam int unsigned BUF_DEPTH = 2;
   localparam int unsigned BUF_PTR_W = $clog2(BUF_DEPTH);
   localparam int unsigned BUF_CNT_W = $clog2(BUF_DEPTH + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      FIN   = 2'd3
   } state_t;

   // True for every state that belongs to an active burst.
   function automatic logic state_busy(input state_t s);
      return s != IDLE;
   endfunction

endpackage

// File: rtl/mem_rd_buf.sv
// Two-entry first-word-fall-through FIFO. When empty, a word being pushed is
// presented at the head in the same cycle, so a ready consumer takes it without
// it ever being stored; that keeps the stream at one beat per cycle.
module mem_rd_buf
   import mem_rd_pkg::*;
#(
   parameter int unsigned WIDTH = DATA_WIDTH_DEF
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 push,
   input  logic [WIDTH-1:0]     push_data,
   input  logic                 pop,
   output logic [WIDTH-1:0]     head_data,
   output logic                 head_valid,
   output logic [BUF_CNT_W-1:0] count
);

   logic [WIDTH-1:0]     entry_q [BUF_DEPTH];
   logic [BUF_PTR_W-1:0] rd_ptr_q;
   logic [BUF_PTR_W-1:0] wr_ptr_q;
   logic                 store_c;
   logic                 drain_c;
   logic                 empty_c;

   // A push bypasses storage only when the FIFO is empty and the head is popped.
   assign empty_c    = (count == '0);
   assign store_c    = push && !(empty_c && pop);
   assign drain_c    = pop && !empty_c;
   assign head_valid = push || !empty_c;
   assign head_data  = empty_c ? push_data : entry_q[rd_ptr_q];

   // Storage, pointers and occupancy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(BUF_DEPTH); i++) begin
            entry_q[i] <= '0;
         end
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count    <= '0;
      end else begin
         if (store_c) begin
            entry_q[wr_ptr_q] <= push_data;
            wr_ptr_q          <= BUF_PTR_W'(wr_ptr_q + 1'b1);
         end
         if (drain_c) begin
            rd_ptr_q <= BUF_PTR_W'(rd_ptr_q + 1'b1);
         end
         count <= BUF_CNT_W'(count + BUF_CNT_W'(store_c) - BUF_CNT_W'(drain_c));
      end
   end

endmodule

// File: rtl/mem_rd_streamer.sv
// Burst read master for the dual-port word memory: issues reads for
// (base_addr, length) and streams the returned words out as valid/ready with a
// last marker. Define MEM_RD_CHECKSUM_EN to add a running sum of the streamed
// words on the checksum output.
module mem_rd_streamer
   import mem_rd_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter int unsigned LEN_WIDTH  = LEN_WIDTH_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [LEN_WIDTH-1:0]  length,
   output logic                  busy,
   output logic                  done,
   output logic                  mem_read_en,
   output logic [ADDR_WIDTH-1:0] mem_read_address,
   input  logic [DATA_WIDTH-1:0] mem_data_out,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic                  m_last
`ifdef MEM_RD_CHECKSUM_EN
   ,
   output logic [DATA_WIDTH-1:0] checksum
`endif
);

   state_t                state_q;
   state_t                state_n;
   logic [ADDR_WIDTH-1:0] rd_ptr_q;
   logic [LEN_WIDTH-1:0]  issue_cnt_q;
   logic [LEN_WIDTH-1:0]  beat_cnt_q;
   logic                  inflight_q;
   logic                  accept_c;
   logic                  issue_c;
   logic                  xfer_c;
   logic [BUF_CNT_W-1:0]  buf_count;
   logic [BUF_CNT_W-1:0]  occupancy_c;
   logic [DATA_WIDTH-1:0] head_data;
   logic                  head_valid;

   // Words owed to the buffer: stored entries plus the read still in flight.
   assign occupancy_c = BUF_CNT_W'(buf_count + BUF_CNT_W'(inflight_q));
   assign xfer_c      = head_valid && m_ready;

   // Next-state, command acceptance and read issue.
   always_comb begin
      state_n  = state_q;
      accept_c = 1'b0;
      issue_c  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               accept_c = 1'b1;
               state_n  = (length == '0) ? FIN : RUN;
            end
         end
         RUN: begin
            issue_c = (issue_cnt_q != '0) && (occupancy_c < BUF_CNT_W'(BUF_DEPTH));
            if ((issue_cnt_q == '0) || (issue_c && (issue_cnt_q == LEN_WIDTH'(1)))) begin
               state_n = DRAIN;
            end
         end
         DRAIN: begin
            if ((beat_cnt_q == '0) || (xfer_c && (beat_cnt_q == LEN_WIDTH'(1)))) begin
               state_n = FIN;
            end
         end
         FIN: begin
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   // State register with busy/done decoded from the next state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         state_q <= state_n;
         busy    <= state_busy(state_n);
         done    <= (state_n == FIN);
      end
   end

   // Read pointer, issue/beat counters and the in-flight flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr_q    <= '0;
         issue_cnt_q <= '0;
         beat_cnt_q  <= '0;
         inflight_q  <= 1'b0;
      end else begin
         inflight_q <= issue_c;
         if (accept_c) begin
            rd_ptr_q    <= base_addr;
            issue_cnt_q <= length;
            beat_cnt_q  <= length;
         end else begin
            if (issue_c) begin
               rd_ptr_q    <= ADDR_WIDTH'(rd_ptr_q + 1'b1);
               issue_cnt_q <= LEN_WIDTH'(issue_cnt_q - 1'b1);
            end
            if (xfer_c) begin
               beat_cnt_q <= LEN_WIDTH'(beat_cnt_q - 1'b1);
            end
         end
      end
   end

   mem_rd_buf #(
      .WIDTH (DATA_WIDTH)
   ) u_buf (
      .clk        (clk),
      .rst_n      (rst_n),
      .push       (inflight_q),
      .push_data  (mem_data_out),
      .pop        (xfer_c),
      .head_data  (head_data),
      .head_valid (head_valid),
      .count      (buf_count)
   );

   assign mem_read_en      = issue_c;
   assign mem_read_address = rd_ptr_q;
   assign m_valid          = head_valid;
   assign m_data           = head_valid ? head_data : '0;
   assign m_last           = head_valid && (beat_cnt_q == LEN_WIDTH'(1));

`ifdef MEM_RD_CHECKSUM_EN
   // Running sum of transferred words; cleared when a burst is accepted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         checksum <= '0;
      end else if (accept_c) begin
         checksum <= '0;
      end else if (xfer_c) begin
         checksum <= DATA_WIDTH'(checksum + m_data);
      end
   end
`endif

endmodule

// File: tb/tb_mem_rd_streamer.sv
// Self-checking bench for mem_rd_streamer: memory preloaded with mem[i]=i+100,
// a per-cycle model built from burst-level expectations, plus directed bursts.
module tb_mem_rd_streamer;

   localparam int unsigned DW = 32;
   localparam int unsigned AW = 5;
   localparam int unsigned LW = 6;
   localparam int MEM_WORDS = 32;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic [AW-1:0] base_addr;
   logic [LW-1:0] length;
   logic          busy;
   logic          done;
   logic          mem_read_en;
   logic [AW-1:0] mem_read_address;
   logic [DW-1:0] mem_data_out = '0;
   logic [DW-1:0] m_data;
   logic          m_valid;
   logic          m_ready;
   logic          m_last;
`ifdef MEM_RD_CHECKSUM_EN
   logic [DW-1:0] checksum;
`endif

   int mem [MEM_WORDS];

   int n_checks = 0;
   int n_pass   = 0;

   mem_rd_streamer #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .LEN_WIDTH  (LW)
   ) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .start            (start),
      .base_addr        (base_addr),
      .length           (length),
      .busy             (busy),
      .done             (done),
      .mem_read_en      (mem_read_en),
      .mem_read_address (mem_read_address),
      .mem_data_out     (mem_data_out),
      .m_data           (m_data),
      .m_valid          (m_valid),
      .m_ready          (m_ready),
      .m_last           (m_last)
`ifdef MEM_RD_CHECKSUM_EN
      ,
      .checksum         (checksum)
`endif
   );

   always #5 clk = ~clk;

   // Memory with registered read port; data holds when not read.
   always @(posedge clk) begin
      if (mem_read_en) mem_data_out <= DW'(mem[mem_read_address]);
   end

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   // ---------------- per-cycle model ----------------
   int exp_data[$];
   int exp_addr[$];
   int outstanding;
   bit mdl_busy;
   bit mdl_done;
   bit prev_stall;
   int prev_data;
   bit nxt_busy;
   bit nxt_done;

   always @(negedge clk) begin
      if (!rst_n) begin
         exp_data.delete();
         exp_addr.delete();
         outstanding = 0;
         mdl_busy    = 1'b0;
         mdl_done    = 1'b0;
         prev_stall  = 1'b0;
      end else begin
         check("busy", busy, mdl_busy);
         check("done", done, mdl_done);
         if (mem_read_en) begin
            check("rd_occupancy_below_2", outstanding < 2, 1);
            if (exp_addr.size() != 0) begin
               check("rd_addr", mem_read_address, exp_addr[0]);
               void'(exp_addr.pop_front());
            end else begin
               check("rd_en_unexpected", mem_read_en, 0);
            end
         end
         if (exp_data.size() == 0) check("m_valid_idle", m_valid, 0);
         else if (m_valid) check("m_data", m_data, exp_data[0]);
         check("m_last", m_last, m_valid && (exp_data.size() == 1));
         if (prev_stall) begin
            check("stall_valid", m_valid, 1);
            check("stall_data", m_data, prev_data);
         end
         prev_stall = m_valid && !m_ready;
         prev_data  = int'(m_data);

         nxt_busy = mdl_busy;
         nxt_done = 1'b0;
         if (mdl_done) nxt_busy = 1'b0;
         if (mem_read_en) outstanding++;
         if (m_valid && m_ready && exp_data.size() != 0) begin
            void'(exp_data.pop_front());
            outstanding--;
            if (exp_data.size() == 0) nxt_done = 1'b1;
         end
         if (start && !mdl_busy) begin
            nxt_busy = 1'b1;
            for (int i = 0; i < int'(length); i++) begin
               exp_addr.push_back((int'(base_addr) + i) % MEM_WORDS);
               exp_data.push_back(mem[(int'(base_addr) + i) % MEM_WORDS]);
            end
            if (length == '0) nxt_done = 1'b1;
         end
         mdl_busy = nxt_busy;
         mdl_done = nxt_done;
      end
   end

   // ---------------- directed bursts ----------------
   int got [64];
   int gaddr [64];
   int n_got;
   int n_addr;
   int first_v;
   int done_c;
   int busy_c;
   longint csum_at_done;

   function automatic logic ready_at(input int mode, input int cyc);
      return (mode == 0) || (cyc % 3 == 0);
   endfunction

   // Start a burst in cycle 0 and run until done (cycle numbers relative to start).
   task automatic run_burst(input int b, input int l, input int mode, input int restart_at);
      int cyc;
      bit fin;
      n_got = 0; n_addr = 0; first_v = -1; done_c = -1; busy_c = 0;
      csum_at_done = 0; cyc = 0; fin = 1'b0;
      base_addr = AW'(b);
      length    = LW'(l);
      start     = 1'b1;
      m_ready   = ready_at(mode, 0);
      while (!fin && cyc < 200) begin
         @(negedge clk);
         if (m_valid && first_v < 0) first_v = cyc;
         if (m_valid && m_ready && n_got < 64) begin got[n_got] = int'(m_data); n_got++; end
         if (mem_read_en && n_addr < 64) begin gaddr[n_addr] = int'(mem_read_address); n_addr++; end
         if (busy) busy_c++;
         if (done) begin
            done_c = cyc;
            fin    = 1'b1;
`ifdef MEM_RD_CHECKSUM_EN
            csum_at_done = longint'(checksum);
`endif
         end
         @(posedge clk); #1;
         cyc++;
         start = (cyc == restart_at);
         if (start) begin
            base_addr = '0;
            length    = LW'(2);
         end
         m_ready = ready_at(mode, cyc);
      end
      check("burst_completes", fin, 1);
   endtask

   initial begin
      for (int i = 0; i < MEM_WORDS; i++) mem[i] = i + 100;
      rst_n = 1'b0; start = 1'b0; base_addr = '0; length = '0; m_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_rd_en", mem_read_en, 0);
      check("rst_rd_addr", mem_read_address, 0);
      check("rst_m_valid", m_valid, 0);
      check("rst_m_data", m_data, 0);
      check("rst_m_last", m_last, 0);
`ifdef MEM_RD_CHECKSUM_EN
      check("rst_checksum", checksum, 0);
`endif
      rst_n = 1'b1;
      @(posedge clk); #1;

      // base=4, len=5, ready high: one beat per cycle, 104..108
      run_burst(4, 5, 0, -1);
      check("t1_beats", n_got, 5);
      for (int i = 0; i < 5; i++) check($sformatf("t1_data%0d", i), got[i], 104 + i);
      check("t1_first_valid_cycle", first_v, 2);
      check("t1_done_cycle", done_c, 7);
      check("t1_busy_cycles", busy_c, 7);

      // same burst with ready 1,0,0,1,0,0,...
      run_burst(4, 5, 1, -1);
      check("t2_beats", n_got, 5);
      for (int i = 0; i < 5; i++) check($sformatf("t2_data%0d", i), got[i], 104 + i);

      // wrap-around
      run_burst(30, 4, 0, -1);
      check("t3_reads", n_addr, 4);
      check("t3_addr0", gaddr[0], 30);
      check("t3_addr1", gaddr[1], 31);
      check("t3_addr2", gaddr[2], 0);
      check("t3_addr3", gaddr[3], 1);
      check("t3_data0", got[0], 130);
      check("t3_data1", got[1], 131);
      check("t3_data2", got[2], 100);
      check("t3_data3", got[3], 101);

      // empty burst
      run_burst(7, 0, 0, -1);
      check("t4_reads", n_addr, 0);
      check("t4_first_valid", first_v, -1);
      check("t4_done_cycle", done_c, 1);
      check("t4_busy_cycles", busy_c, 1);

      // start re-pulsed mid-burst with base=0 is ignored
      run_burst(8, 6, 0, 3);
      check("t5_beats", n_got, 6);
      for (int i = 0; i < 6; i++) check($sformatf("t5_data%0d", i), got[i], 108 + i);
      check("t5_done_cycle", done_c, 8);

`ifdef MEM_RD_CHECKSUM_EN
      run_burst(0, 3, 0, -1);
      check("t6_checksum", csum_at_done, 303);
`endif

      // reset mid-burst with the buffer backed up
      start = 1'b1; base_addr = AW'(10); length = LW'(10); m_ready = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      check("t7_pre_busy", busy, 1);
      check("t7_pre_valid", m_valid, 1);
      #1 rst_n = 1'b0;
      #1;
      check("t7_busy", busy, 0);
      check("t7_done", done, 0);
      check("t7_rd_en", mem_read_en, 0);
      check("t7_rd_addr", mem_read_address, 0);
      check("t7_m_valid", m_valid, 0);
      check("t7_m_data", m_data, 0);
      check("t7_m_last", m_last, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      m_ready = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      check("t7_idle_busy", busy, 0);
      check("t7_idle_valid", m_valid, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
